reg_scoreboard: RTL
===================

Name: reg_scoreboard

Overview:
- Parametrised pending-write scoreboard for the pipelined CPU register file.
- Decodes issue and writeback destination numbers into one-hot enables, then keeps a saturating in-flight count per register.
- Reports which registers have outstanding writes and flags source-operand hazards for the decode-stage stall logic.
- Sits between ID (issue/lookup) and WB (retire); flush clears all pending state on a pipeline redirect.

Parameters:
- ADDR_W, 5, register-number width; NREG = 2**ADDR_W registers.
- CNT_W, 2, per-register in-flight counter width; max count CMAX = 2**CNT_W-1.
- R0_ZERO, 1, when 1 register 0 is never tracked: issue/wb to 0 ignored, busy for 0 always 0.
- WB_BYPASS, 1, when 1 a same-cycle retiring write clears hazard visibility (see Behaviour).

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous active-high reset.
- IssueEn  in  1  instruction with a destination register leaves ID this cycle.
- IssueAddr  in  ADDR_W  destination register of issuing instruction.
- WbEn  in  1  writeback retires a register write this cycle.
- WbAddr  in  ADDR_W  register being written back.
- Flush  in  1  discard all pending writes (redirect).
- RsAddr  in  ADDR_W  first source register looked up in ID.
- RtAddr  in  ADDR_W  second source register looked up in ID.
- RsBusy  out  1  Rs has an outstanding write.
- RtBusy  out  1  Rt has an outstanding write.
- Pending  out  NREG  bit i = register i count nonzero (registered view).
- IssueErr  out  1  registered; issue attempted on a register already at CMAX.
- WbErr  out  1  registered; writeback on a register with count 0.

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-high, Rst.
- Reset: all counters 0; Pending=0, IssueErr=0, WbErr=0. RsBusy/RtBusy become 0 the cycle after Rst is sampled.
- Decode: IssueAddr and WbAddr go through a one-hot decoder gated by IssueEn and WbEn respectively. Disabled input -> all-zero one-hot.
- Per-register update at the clock edge, for register i:
  - issue only: cnt+1.
  - wb only: cnt-1.
  - both: unchanged.
  - neither: unchanged.
- Saturation:
  - Issue-only at CMAX: count stays CMAX; IssueErr=1 next cycle.
  - Wb-only at 0: count stays 0; WbErr=1 next cycle.
  - Both error flags are single-cycle pulses.
- Flush has priority over all updates: every counter -> 0 next cycle; the same-cycle issue and wb are discarded; no error flags.
- Rst has priority over Flush.
- R0_ZERO=1: register 0 counter is constantly 0; it never raises errors, and its busy and Pending bits are 0.
- Pending[i] = (cnt_i != 0), taken from registered state; 0-cycle combinational from flops.
- RsBusy/RtBusy are combinational from registered counters and the current-cycle WbEn/WbAddr; the lookup does not see this cycle's issue.
  - WB_BYPASS=1: busy = (cnt!=0) && !(WbEn && WbAddr==src && cnt==1).
  - WB_BYPASS=0: busy = (cnt!=0).
  - Flush does not mask busy in the same cycle.
- Address aliasing: IssueAddr==WbAddr with both enabled is legal and nets to zero change.
- Latency: an update issued in cycle N is visible on Pending/busy in cycle N+1.

Decomposition:
- Shared package: constants ADDR_W default, CNT_W default, NREG derivation, and register-number constant REG_ZERO.
- One sub-module, dec_onehot: parametrised N-to-2**N decoder with enable and combinational one-hot output.
  - Instantiated twice, for issue and writeback.
  - Replaces fixed-width gate decoders in future blocks.
- Counter array and busy muxes stay in reg_scoreboard.

Test Plan:
- Reset: Rst=1 for 2 cycles with IssueEn=1 IssueAddr=3 -> Pending=0, IssueErr=0; after release, issue 3 -> Pending=32'h8, RsBusy=1 for RsAddr=3.
- Two issues then retire, reg 7: issue 7 twice, then WbEn with WbAddr=7.
  - After the first wb: Pending[7]=1.
  - WB_BYPASS=1: in the cycle of the second wb, RsBusy (RsAddr=7) is 0 combinationally; Pending[7]=0 next cycle.
- Simultaneous events: reg 5 at count 1, IssueEn and WbEn both to 5 -> count stays 1, Pending[5]=1, no error.
- Saturation, CNT_W=2:
  - Four issues to reg 9 -> count 3, IssueErr pulses 1 cycle after the 4th.
  - Wb to reg 12 at 0 -> WbErr pulse, Pending[12]=0.
- R0 and flush:
  - Issue to 0 -> Pending[0]=0, RtBusy(RtAddr=0)=0.
  - Load regs 1, 31 pending, then Flush with an issue to 4 -> Pending=0 next cycle.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register-file pending-write scoreboard.
// Contents:
//   ADDR_W_DEF / CNT_W_DEF : default register-number and counter widths
//   NREG_DEF, nreg_of()    : register count derived from the address width
//   REG_ZERO               : register number of the hard-wired zero register
//   upd_e                  : per-register counter action for one clock edge
package reg_scoreboard_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 2;
    localparam int REG_ZERO   = 0;

    // Number of architectural registers addressed by an address of width w.
    function automatic int nreg_of(input int w);
        return 2 ** w;
    endfunction

    localparam int NREG_DEF = nreg_of(ADDR_W_DEF);

    typedef enum logic [1:0] {
        UPD_HOLD = 2'd0,
        UPD_INC  = 2'd1,
        UPD_DEC  = 2'd2
    } upd_e;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Bus bundle between the ID/WB stages and the scoreboard.
// master: pipeline side (drives issue, writeback, flush and lookups).
// slave : scoreboard side (returns busy flags, pending vector and errors).
//   IssueEn/IssueAddr : destination of the instruction leaving ID
//   WbEn/WbAddr       : register retired by writeback
//   Flush             : discard all pending writes
//   RsAddr/RtAddr     : source registers looked up in ID
//   RsBusy/RtBusy     : source has an outstanding write
//   Pending           : per-register outstanding-write vector
//   IssueErr/WbErr    : single-cycle saturation error pulses
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic                      IssueEn;
    logic [ADDR_W-1:0]         IssueAddr;
    logic                      WbEn;
    logic [ADDR_W-1:0]         WbAddr;
    logic                      Flush;
    logic [ADDR_W-1:0]         RsAddr;
    logic [ADDR_W-1:0]         RtAddr;
    logic                      RsBusy;
    logic                      RtBusy;
    logic [(2**ADDR_W)-1:0]    Pending;
    logic                      IssueErr;
    logic                      WbErr;

    modport master (
        output IssueEn, IssueAddr, WbEn, WbAddr, Flush, RsAddr, RtAddr,
        input  RsBusy, RtBusy, Pending, IssueErr, WbErr
    );

    modport slave (
        input  IssueEn, IssueAddr, WbEn, WbAddr, Flush, RsAddr, RtAddr,
        output RsBusy, RtBusy, Pending, IssueErr, WbErr
    );

endinterface

// File: rtl/reg_scoreboard_dec_onehot.sv
// Generic N-to-2**N one-hot decoder with enable.
//   en     : when low the output is all zeros
//   addr   : N-bit index to decode
//   onehot : 2**N-bit combinational one-hot result
module dec_onehot #(
    parameter int N = 5
) (
    input  logic                en,
    input  logic [N-1:0]        addr,
    output logic [(2**N)-1:0]   onehot
);

    localparam int M = 2 ** N;

    // Set exactly one output bit when enabled.
    always_comb begin
        onehot = {M{1'b0}};
        if (en) begin
            onehot[addr] = 1'b1;
        end else begin
            onehot = {M{1'b0}};
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the pipelined register file.
// Keeps a saturating in-flight write count per register, reports which
// registers have outstanding writes and flags source-operand hazards.
//   Clk, Rst : clock and synchronous active-high reset
//   bus      : reg_scoreboard_if slave (issue, writeback, flush, lookups,
//              busy flags, Pending vector, IssueErr/WbErr pulses)
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int R0_ZERO   = 1,
    parameter int WB_BYPASS = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    reg_scoreboard_if.slave   bus
);

    localparam int              NREG     = nreg_of(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CMAX     = {CNT_W{1'b1}};

    logic [NREG-1:0]  iss_oh_s;
    logic [NREG-1:0]  wb_oh_s;
    upd_e             upd_s [NREG];
    logic [NREG-1:0]  iss_sat_s;
    logic [NREG-1:0]  wb_sat_s;
    logic [NREG-1:0]  pending_s;
    logic [CNT_W-1:0] cnt_r [NREG];
    logic             issue_err_r;
    logic             wb_err_r;
    logic [CNT_W-1:0] rs_cnt_s;
    logic [CNT_W-1:0] rt_cnt_s;
    logic             rs_busy_s;
    logic             rt_busy_s;

    dec_onehot #(.N(ADDR_W)) u_dec_issue (
        .en     (bus.IssueEn),
        .addr   (bus.IssueAddr),
        .onehot (iss_oh_s)
    );

    dec_onehot #(.N(ADDR_W)) u_dec_wb (
        .en     (bus.WbEn),
        .addr   (bus.WbAddr),
        .onehot (wb_oh_s)
    );

    // Per-register action and saturation detection; an aliased issue+wb nets to hold.
    always_comb begin
        iss_sat_s = {NREG{1'b0}};
        wb_sat_s  = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            upd_s[i] = UPD_HOLD;
            if ((R0_ZERO != 0) && (i == REG_ZERO)) begin
                upd_s[i] = UPD_HOLD;
            end else begin
                case ({iss_oh_s[i], wb_oh_s[i]})
                    2'b10:   upd_s[i] = UPD_INC;
                    2'b01:   upd_s[i] = UPD_DEC;
                    default: upd_s[i] = UPD_HOLD;
                endcase
            end
            iss_sat_s[i] = (upd_s[i] == UPD_INC) && (cnt_r[i] == CMAX);
            wb_sat_s[i]  = (upd_s[i] == UPD_DEC) && (cnt_r[i] == CNT_ZERO);
        end
    end

    // Counter array: reset beats flush, flush beats any same-cycle update.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NREG; i++) cnt_r[i] <= CNT_ZERO;
        end else if (bus.Flush) begin
            for (int i = 0; i < NREG; i++) cnt_r[i] <= CNT_ZERO;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                case (upd_s[i])
                    UPD_INC: if (cnt_r[i] != CMAX)     cnt_r[i] <= cnt_r[i] + CNT_ONE;
                    UPD_DEC: if (cnt_r[i] != CNT_ZERO) cnt_r[i] <= cnt_r[i] - CNT_ONE;
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    // Single-cycle error pulses; a flushed cycle reports nothing.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            issue_err_r <= 1'b0;
            wb_err_r    <= 1'b0;
        end else if (bus.Flush) begin
            issue_err_r <= 1'b0;
            wb_err_r    <= 1'b0;
        end else begin
            issue_err_r <= |iss_sat_s;
            wb_err_r    <= |wb_sat_s;
        end
    end

    // Pending view straight from the counter flops.
    always_comb begin
        pending_s = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            pending_s[i] = (cnt_r[i] != CNT_ZERO);
        end
    end

    // Source lookups; a retiring last write to the source hides the hazard.
    always_comb begin
        rs_cnt_s  = cnt_r[bus.RsAddr];
        rt_cnt_s  = cnt_r[bus.RtAddr];
        rs_busy_s = (rs_cnt_s != CNT_ZERO);
        rt_busy_s = (rt_cnt_s != CNT_ZERO);
        if (WB_BYPASS != 0) begin
            if (bus.WbEn && (bus.WbAddr == bus.RsAddr) && (rs_cnt_s == CNT_ONE)) begin
                rs_busy_s = 1'b0;
            end else begin
                rs_busy_s = (rs_cnt_s != CNT_ZERO);
            end
            if (bus.WbEn && (bus.WbAddr == bus.RtAddr) && (rt_cnt_s == CNT_ONE)) begin
                rt_busy_s = 1'b0;
            end else begin
                rt_busy_s = (rt_cnt_s != CNT_ZERO);
            end
        end else begin
            rs_busy_s = (rs_cnt_s != CNT_ZERO);
            rt_busy_s = (rt_cnt_s != CNT_ZERO);
        end
    end

    assign bus.Pending  = pending_s;
    assign bus.RsBusy   = rs_busy_s;
    assign bus.RtBusy   = rt_busy_s;
    assign bus.IssueErr = issue_err_r;
    assign bus.WbErr    = wb_err_r;

endmodule
